// File: rtl/spi_frame_scheduler_if.sv
// Bus bundle between spi_frame_scheduler, spi_driver and the application write requesters.
// slave = scheduler side, master = the environment driving it.
interface spi_frame_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WORDS = 64,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(WORDS);

  logic                  busy;
  logic                  wdog_alarm;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    waddr;
  logic [NREQ*32-1:0]    wdata;
  logic [NREQ-1:0]       gnt;
  logic [WORDS*32-1:0]   copi_data;
  logic [WORDS*32-1:0]   cipo_data;
  logic [AW-1:0]         rd_addr;
  logic [31:0]           rd_data;
  logic                  frame_done;
  logic [CNT_W-1:0]      frame_count;
  logic                  frame_err;

  modport slave (
    input  busy, wdog_alarm, req, waddr, wdata, copi_data, rd_addr,
    output gnt, cipo_data, rd_data, frame_done, frame_count, frame_err
  );

  modport master (
    output busy, wdog_alarm, req, waddr, wdata, copi_data, rd_addr,
    input  gnt, cipo_data, rd_data, frame_done, frame_count, frame_err
  );
endinterface

// File: rtl/spi_frame_scheduler.sv
// Frame-coherent cipo staging with an arbitrated word write port, plus copi snapshot readback.
// Define SPI_SCHED_RR_EN for round-robin arbitration; fixed priority (req[0] highest) otherwise.
//
// state  | meaning
// IDLE   | no frame; cipo_data tracks the staging buffer every cycle
// LOCKED | frame in progress; cipo_data frozen
// COMMIT | frame ended cleanly; snapshot copi_data, count it, clear frame_err
// ABORT  | watchdog fired during the frame; set frame_err, nothing captured
module spi_frame_scheduler #(
  parameter int NREQ  = 4,
  parameter int WORDS = 64,
  parameter int CNT_W = 16
) (
  input  logic           sysclock,
  input  logic           sysreset,
  spi_frame_scheduler_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, LOCKED, COMMIT, ABORT} state_t;

  state_t                  state_q, state_d;
  logic                    busy_m_q, busy_s_q;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic [NREQ-1:0]         req_m;
  logic                    win_vld;
  logic [IW-1:0]           win_idx;
  logic [AW-1:0]           wa_q, wa_d;
  logic [31:0]             wd_q, wd_d;
  logic [WORDS-1:0][31:0]  staging_q, staging_d;
  logic [WORDS-1:0][31:0]  cipo_q, cipo_d;
  logic [WORDS-1:0][31:0]  snap_q, snap_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic [CNT_W-1:0]        frame_count_q, frame_count_d;
  logic                    frame_err_q, frame_err_d;
`ifdef SPI_SCHED_RR_EN
  logic [IW-1:0]           ptr_q, ptr_d;
`endif

  // A requester still holds req during its grant cycle, so the granted one is masked out.
  always_comb begin
    req_m   = bus.req & ~gnt_q;
    win_vld = 1'b0;
    win_idx = '0;
`ifdef SPI_SCHED_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && req_m[IW'(int'(ptr_q) + k)]) begin
        win_vld = 1'b1;
        win_idx = IW'(int'(ptr_q) + k);
      end
    end
    ptr_d = win_vld ? win_idx : ptr_q;
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_m[i]) begin
        win_vld = 1'b1;
        win_idx = IW'(i);
      end
    end
`endif
    gnt_d = '0;
    if (win_vld) gnt_d[win_idx] = 1'b1;
    wa_d = bus.waddr[win_idx*AW +: AW];
    wd_d = bus.wdata[win_idx*32 +: 32];
  end

  always_comb begin
    state_d       = state_q;
    staging_d     = staging_q;
    cipo_d        = cipo_q;
    snap_d        = snap_q;
    frame_count_d = frame_count_q;
    frame_err_d   = frame_err_q;
    if (|gnt_q) staging_d[wa_q] = wd_q;
    rd_data_d = snap_q[bus.rd_addr];
    case (state_q)
      IDLE: begin
        // Publishing staging_d lets a write landing this cycle reach cipo_data next cycle.
        if (busy_s_q) state_d = LOCKED;
        else          cipo_d  = staging_d;
      end
      LOCKED: begin
        if (bus.wdog_alarm)  state_d = ABORT;
        else if (!busy_s_q)  state_d = COMMIT;
      end
      COMMIT: begin
        snap_d        = bus.copi_data;
        frame_count_d = frame_count_q + 1'b1;
        frame_err_d   = 1'b0;
        state_d       = IDLE;
      end
      ABORT: begin
        frame_err_d = 1'b1;
        state_d     = busy_s_q ? LOCKED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclock or posedge sysreset) begin
    if (sysreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge sysclock or posedge sysreset) begin
    if (sysreset) begin
      busy_m_q      <= 1'b0;
      busy_s_q      <= 1'b0;
      gnt_q         <= '0;
      wa_q          <= '0;
      wd_q          <= '0;
      staging_q     <= '0;
      cipo_q        <= '0;
      snap_q        <= '0;
      rd_data_q     <= '0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
`ifdef SPI_SCHED_RR_EN
      ptr_q         <= IW'(NREQ - 1);
`endif
    end else begin
      busy_m_q      <= bus.busy;
      busy_s_q      <= busy_m_q;
      gnt_q         <= gnt_d;
      wa_q          <= wa_d;
      wd_q          <= wd_d;
      staging_q     <= staging_d;
      cipo_q        <= cipo_d;
      snap_q        <= snap_d;
      rd_data_q     <= rd_data_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
`ifdef SPI_SCHED_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.cipo_data   = cipo_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.frame_done  = (state_q == COMMIT);
  assign bus.frame_count = frame_count_q;
  assign bus.frame_err   = frame_err_q;
endmodule
